// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and types for the FIR datapath blocks.
//   FIR_PROD_W / FIR_COEF_W / FIR_SAMP_W : default datapath widths
//   fsm_t                                : accumulator frame state
//   ROUND_CONVERGENT                     : rounding mode, selected at build time
// Build option: define FIR_ACCUM_CONVERGENT_EN for round-half-to-even;
// the default build rounds half up.
package fir_pkg;

  localparam int FIR_PROD_W = 48;
  localparam int FIR_COEF_W = 25;
  localparam int FIR_SAMP_W = 18;

  typedef enum logic {
    IDLE  = 1'b0,  // no frame open
    ACCUM = 1'b1   // frame open, taps being summed
  } fsm_t;

`ifdef FIR_ACCUM_CONVERGENT_EN
  localparam bit ROUND_CONVERGENT = 1'b1;
`else
  localparam bit ROUND_CONVERGENT = 1'b0;
`endif

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: combinational round, arithmetic shift and saturate.
//   sum : signed IN_W-bit accumulator result
//   y   : signed OUT_W-bit rounded/clamped sample
//   sat : result was clamped to an output limit
// Rounding mode comes from fir_pkg::ROUND_CONVERGENT (build option
// FIR_ACCUM_CONVERGENT_EN). Requires IN_W-OUT_SHIFT+1 >= OUT_W.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int IN_W      = 48,
  parameter int OUT_W     = 24,
  parameter int OUT_SHIFT = 23
) (
  input  logic signed [IN_W-1:0]  sum,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  // One extra bit over the shifted width so the +1 from rounding can't wrap.
  localparam int QW = IN_W - OUT_SHIFT + 1;
  localparam logic [OUT_SHIFT-1:0] HALF = OUT_SHIFT'(1) << (OUT_SHIFT - 1);
  localparam logic signed [QW-1:0] MAXV = {{(QW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [QW-1:0] MINV = {{(QW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [QW-1:0]  q;     // floor(sum / 2^OUT_SHIFT)
  logic signed [QW-1:0]  r;     // rounded quotient
  logic [OUT_SHIFT-1:0]  frac;  // bits shifted out
  logic                  inc;

  assign q    = QW'(sum >>> OUT_SHIFT);
  assign frac = sum[OUT_SHIFT-1:0];

  // floor + (frac >= half) is the same as (sum + half) >>> OUT_SHIFT.
  // Convergent mode only differs at an exact tie, where it rounds toward
  // the even quotient.
  generate
    if (ROUND_CONVERGENT) begin : g_conv
      assign inc = frac[OUT_SHIFT-1] & (((frac & ~HALF) != '0) | q[0]);
    end else begin : g_half_up
      assign inc = frac[OUT_SHIFT-1];
    end
  endgenerate

  assign r = q + {{(QW-1){1'b0}}, inc};

  always_comb begin
    y   = r[OUT_W-1:0];
    sat = 1'b0;
    if (r > MAXV) begin
      y   = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (r < MINV) begin
      y   = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/fir_accum_round.sv
// fir_accum_round: sums NUM_TAPS signed products per frame, then rounds,
// shifts and saturates to OUT_W and presents the sample on valid/ready.
//   clk, reset      : clock, synchronous active-high reset
//   prod_valid/first/data : product stream (no backpressure)
//   out_valid/ready/data  : one-deep output register
//   sat_flag, overrun_flag, frame_err : sticky status, cleared by status_clr
// Build option FIR_ACCUM_CONVERGENT_EN selects round-half-to-even
// (see fir_pkg); latency is the same either way.
// Latency: last product sampled at cycle t -> out_valid at cycle t+2.
module fir_accum_round
  import fir_pkg::*;
#(
  parameter int NUM_TAPS  = 32,
  parameter int PROD_W    = FIR_PROD_W,
  parameter int ACC_W     = 48,
  parameter int OUT_W     = 24,
  parameter int OUT_SHIFT = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    prod_valid,
  input  logic                    prod_first,
  input  logic signed [PROD_W-1:0] prod_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    sat_flag,
  output logic                    overrun_flag,
  output logic                    frame_err,
  input  logic                    status_clr
);

  localparam int CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  fsm_t                    state;
  logic [CNT_W-1:0]        tap_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;

  // Round stage: completed frame sum, valid for one cycle.
  logic signed [ACC_W-1:0] sum_q;
  logic                    sum_vld;

  logic signed [OUT_W-1:0] rs_y;
  logic                    rs_sat;

  // Event strobes feeding the sticky flags.
  logic fe_set;
  logic ov_set;
  logic sat_set;

  assign prod_ext = ACC_W'(prod_data);

  // Accumulator / framing FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tap_cnt <= '0;
      acc     <= '0;
      sum_q   <= '0;
      sum_vld <= 1'b0;
    end else begin
      sum_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (prod_valid && prod_first) begin
            acc     <= prod_ext;
            tap_cnt <= CNT_W'(1);
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            if (prod_first) begin
              // Early restart: the new product opens a fresh frame.
              acc     <= prod_ext;
              tap_cnt <= CNT_W'(1);
            end else if (tap_cnt == LAST_TAP) begin
              sum_q   <= acc + prod_ext;
              sum_vld <= 1'b1;
              acc     <= '0;
              tap_cnt <= '0;
              state   <= IDLE;
            end else begin
              acc     <= acc + prod_ext;
              tap_cnt <= tap_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Framing violations: orphan product in IDLE, or a first mid-frame.
  assign fe_set = prod_valid &&
                  (((state == IDLE) && !prod_first) || ((state == ACCUM) && prod_first));

  fir_round_sat #(
    .IN_W      (ACC_W),
    .OUT_W     (OUT_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .sum (sum_q),
    .y   (rs_y),
    .sat (rs_sat)
  );

  // A new result can be taken when the register is empty or is being
  // drained this cycle; otherwise it is dropped and the held one kept.
  assign ov_set  = sum_vld && out_valid && !out_ready;
  assign sat_set = sum_vld && rs_sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (sum_vld && !ov_set) begin
      out_valid <= 1'b1;
      out_data  <= rs_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky flags: a set in the same cycle as status_clr wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flag     <= 1'b0;
      overrun_flag <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sat_flag     <= sat_set | (sat_flag     & ~status_clr);
      overrun_flag <= ov_set  | (overrun_flag & ~status_clr);
      frame_err    <= fe_set  | (frame_err    & ~status_clr);
    end
  end

endmodule

// File: tb/tb_fir_accum_round.sv
module tb_fir_accum_round;

  localparam int NUM_TAPS  = 4;
  localparam int PROD_W    = 16;
  localparam int ACC_W     = 20;
  localparam int OUT_W     = 8;
  localparam int OUT_SHIFT = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     prod_valid;
  logic                     prod_first;
  logic signed [PROD_W-1:0] prod_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     sat_flag;
  logic                     overrun_flag;
  logic                     frame_err;
  logic                     status_clr;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  fir_accum_round #(
    .NUM_TAPS (NUM_TAPS),
    .PROD_W   (PROD_W),
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .prod_valid  (prod_valid),
    .prod_first  (prod_first),
    .prod_data   (prod_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .sat_flag    (sat_flag),
    .overrun_flag(overrun_flag),
    .frame_err   (frame_err),
    .status_clr  (status_clr)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is popped against the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0d expected none", int'(out_data));
      end else begin
        chk("out_data", int'(out_data), exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prod(input bit first, input int d);
    prod_valid = 1'b1;
    prod_first = first;
    prod_data  = PROD_W'(d);
    step();
    prod_valid = 1'b0;
    prod_first = 1'b0;
  endtask

  task automatic frame(input int a, input int b, input int c, input int d);
    prod(1'b1, a);
    prod(1'b0, b);
    prod(1'b0, c);
    prod(1'b0, d);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic clr_status();
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    prod_valid = 1'b0;
    prod_first = 1'b0;
    prod_data  = '0;
    out_ready  = 1'b1;
    status_clr = 1'b0;
    step();
    step();
    reset = 1'b0;

    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data), 0);
    chk("rst_sat",       int'(sat_flag), 0);
    chk("rst_overrun",   int'(overrun_flag), 0);
    chk("rst_frame_err", int'(frame_err), 0);

    // Basic frame: (160+8)>>4 = 10, then back-to-back zero frame.
    exp_q.push_back(10);
    frame(16, 32, 48, 64);
    chk("lat_t1_valid", int'(out_valid), 0);
    exp_q.push_back(0);
    prod(1'b1, 0);
    chk("lat_t2_valid", int'(out_valid), 1);
    chk("lat_t2_data",  int'(out_data), 10);
    prod(1'b0, 0);
    chk("one_cycle_valid", int'(out_valid), 0);
    prod(1'b0, 0);
    prod(1'b0, 0);
    drain();
    chk("no_frame_err", int'(frame_err), 0);

    // Rounding ties.
`ifdef FIR_ACCUM_CONVERGENT_EN
    exp_q.push_back(2);
    exp_q.push_back(-2);
`else
    exp_q.push_back(3);
    exp_q.push_back(-1);
`endif
    exp_q.push_back(2);
    frame(10, 10, 10, 10);
    frame(-6, -6, -6, -6);
    frame(6, 6, 6, 6);
    drain();
    chk("no_sat_yet", int'(sat_flag), 0);

    // Saturation both ways.
    exp_q.push_back(127);
    frame(800, 800, 800, 800);
    drain();
    chk("sat_pos_flag", int'(sat_flag), 1);
    exp_q.push_back(-128);
    frame(-800, -800, -800, -800);
    drain();
    clr_status();
    chk("sat_cleared", int'(sat_flag), 0);

    // Backpressure: A held, B dropped.
    out_ready = 1'b0;
    exp_q.push_back(10);
    frame(40, 40, 40, 40);
    frame(16, 16, 16, 16);
    step();
    step();
    chk("bp_valid_held", int'(out_valid), 1);
    chk("bp_data_held",  int'(out_data), 10);
    chk("bp_overrun",    int'(overrun_flag), 1);
    out_ready = 1'b1;
    drain();
    repeat (4) step();
    clr_status();
    chk("overrun_cleared", int'(overrun_flag), 0);

    // Framing: first on tap 2 restarts; (128+8)>>4 = 8.
    exp_q.push_back(8);
    prod(1'b1, 16);
    prod(1'b0, 16);
    prod(1'b1, 32);
    chk("fe_restart", int'(frame_err), 1);
    prod(1'b0, 32);
    prod(1'b0, 32);
    chk("restart_no_out_yet", exp_q.size(), 1);
    prod(1'b0, 32);
    drain();
    clr_status();
    chk("fe_cleared", int'(frame_err), 0);
    prod(1'b0, 5);
    chk("fe_orphan", int'(frame_err), 1);
    exp_q.push_back(4);
    frame(16, 16, 16, 16);
    drain();

    // Reset mid-frame discards the partial sum.
    prod(1'b1, 16);
    prod(1'b0, 16);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_frame_err", int'(frame_err), 0);
    repeat (3) step();
    chk("rst2_no_out", int'(out_valid), 0);
    exp_q.push_back(4);
    frame(16, 16, 16, 16);
    drain();
    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
